reaction_timer_ctrl: RTL and testbench

Sequencing controller for the reaction-timer game. Consumes the 1 ms tick from the clock-divider stage and runs each round: a pseudo-random wait, GO indication, millisecond counting of the player's response, and result hold. Drives the GO LED and supplies the result value and status flags to the display logic.

---
 rtl/reaction_timer_ctrl.sv | 108 ++++++++++
 tb/tb_reaction_timer_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: round sequencer for the reaction-timer game (random wait, GO, ms count, result hold)
// Ports:
//   clock        system clock, sole clock domain
//   reset        asynchronous active-low reset
//   tick_1ms     one-cycle enable pulse every millisecond
//   start_pulse  one-cycle start request (honoured in IDLE and DONE)
//   react_pulse  one-cycle player response
//   led_go       high while in GO
//   time_ms      reaction count in ms, saturates at TIMEOUT_MS
//   result_valid high in DONE after a timed or timeout round
//   early_flag   high in DONE after a false start
//   busy         high in WAIT or GO
//   best_ms      best valid time; present only when REACTION_BEST_EN is defined
module reaction_timer_ctrl #(
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 11,
    parameter int          TIMEOUT_MS   = 9999,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick_1ms,
    input  logic        start_pulse,
    input  logic        react_pulse,
    output logic        led_go,
    output logic [13:0] time_ms,
    output logic        result_valid,
    output logic        early_flag,
    output logic        busy
`ifdef REACTION_BEST_EN
    ,
    output logic [13:0] best_ms
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT, GO, DONE} state_t;
    state_t      state, state_nx;
    logic [15:0] lfsr;
    logic [13:0] delay_cnt, delay_nx, time_nx, time_inc;
    logic        valid_nx, early_nx;
    assign time_inc = time_ms + 14'd1;
    always_comb begin
        state_nx = state;
        delay_nx = delay_cnt;
        time_nx  = time_ms;
        valid_nx = result_valid;
        early_nx = early_flag;
        case (state)
            IDLE, DONE: if (start_pulse) begin
                state_nx = WAIT;
                delay_nx = 14'(MIN_DELAY_MS) + 14'(lfsr[RAND_BITS-1:0]);
                time_nx  = '0;
                valid_nx = 1'b0;
                early_nx = 1'b0;
            end
            WAIT: if (react_pulse) begin
                // a false start wins over a tick in the same cycle
                state_nx = DONE;
                early_nx = 1'b1;
                time_nx  = '0;
            end else if (tick_1ms) begin
                delay_nx = delay_cnt - 14'd1;
                state_nx = (delay_cnt == 14'd1) ? GO : WAIT;
            end
            GO: begin
                // a coincident tick is counted before the response freezes the value
                if (tick_1ms) time_nx = time_inc;
                if (react_pulse || (tick_1ms && time_inc == 14'(TIMEOUT_MS))) begin
                    state_nx = DONE;
                    valid_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
`ifdef REACTION_BEST_EN
    logic best_ld;
    assign best_ld = (state != DONE) && (state_nx == DONE) && valid_nx &&
                     (time_nx < best_ms) && (time_nx != 14'(TIMEOUT_MS));
`endif
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            delay_cnt    <= '0;
            time_ms      <= '0;
            result_valid <= 1'b0;
            early_flag   <= 1'b0;
            led_go       <= 1'b0;
            busy         <= 1'b0;
`ifdef REACTION_BEST_EN
            best_ms      <= 14'(TIMEOUT_MS);
`endif
        end else begin
            state        <= state_nx;
            // Galois form of x^16+x^14+x^13+x^11+1
            lfsr         <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            delay_cnt    <= delay_nx;
            time_ms      <= time_nx;
            result_valid <= valid_nx;
            early_flag   <= early_nx;
            led_go       <= state_nx == GO;
            busy         <= (state_nx == WAIT) || (state_nx == GO);
`ifdef REACTION_BEST_EN
            if (best_ld) best_ms <= time_nx;
`endif
        end
    end
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb_reaction_timer_ctrl: randomized round-level scoreboard bench for reaction_timer_ctrl
module tb_reaction_timer_ctrl;
    logic        clk = 0, rst_n = 0, tick = 0, start = 0, react = 0;
    logic        led_go, result_valid, early_flag, busy;
    logic [13:0] time_ms;
`ifdef REACTION_BEST_EN
    logic [13:0] best_ms;
`endif
    always #5 clk = ~clk;

    reaction_timer_ctrl dut (
        .clock(clk), .reset(rst_n), .tick_1ms(tick), .start_pulse(start), .react_pulse(react),
        .led_go(led_go), .time_ms(time_ms), .result_valid(result_valid),
        .early_flag(early_flag), .busy(busy)
`ifdef REACTION_BEST_EN
        , .best_ms(best_ms)
`endif
    );

    typedef struct {int kind; int cyc; int t; bit v; bit e; int best;} ev_t;
    ev_t q[$];
    ev_t last;
    int  cyc = 0, n_chk = 0, n_fail = 0, exp_best = 9999;
    bit  pb, pg, have_done;
    logic [15:0] m_lfsr;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= 16'hACE1;
        else m_lfsr <= lfsr_next(m_lfsr);

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit t, input bit s, input bit r);
        tick = t; start = s; react = r;
        @(posedge clk);
        #1;
        tick = 0; start = 0; react = 0;
    endtask

    task automatic push(input int kind, input int t, input bit v, input bit e);
        ev_t x;
        x.kind = kind; x.cyc = cyc; x.t = t; x.v = v; x.e = e; x.best = exp_best;
        q.push_back(x);
    endtask

    task automatic ticks(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) drive(0, noise && ($urandom_range(0, 1) == 1), 0);
            drive(1, 0, 0);
        end
    endtask

    task automatic check_reset();
        chk("rst_led_go", led_go, 0);
        chk("rst_time_ms", time_ms, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_early_flag", early_flag, 0);
        chk("rst_busy", busy, 0);
`ifdef REACTION_BEST_EN
        chk("rst_best_ms", best_ms, 9999);
`endif
    endtask

    // kind: 0 false start after n wait ticks, 1 react after n GO ticks, 2 timeout, 3 reset at n GO ticks
    task automatic round(input int kind, input int n, input bit same);
        int d, t;
        d = 1000 + int'(m_lfsr[10:0]);
        drive(0, 1, 0);
        push(0, 0, 0, 0);
        if (kind == 0) begin
            ticks(n, 1);
            drive(same, 0, 1);
            push(2, 0, 0, 1);
        end else begin
            ticks(d - 1, 1);
            drive(1, 0, 0);
            push(1, 0, 0, 0);
            if (kind == 1) begin
                ticks(n, 1);
                drive(same, 0, 1);
                t = n + int'(same);
                if (t < exp_best) exp_best = t;
                push(2, t, 1, 0);
            end else if (kind == 2) begin
                ticks(9998, 1);
                drive(1, 0, 0);
                push(2, 9999, 1, 0);
            end else begin
                ticks(n, 1);
                chk("pre_reset_time", time_ms, n);
                #1 rst_n = 0;
                #1 check_reset();
                exp_best = 9999;
                q.delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
            end
        end
        if (kind != 3) begin
            ticks(5, 0);
            drive(0, 0, 1);
            drive(1, 0, 1);
            repeat (3) drive(0, 0, 0);
        end
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            chk("unexpected_event", kind, -1);
            return;
        end
        e = q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.cyc);
        if (kind != 2) chk("count_start", time_ms, 0);
        if (kind == 2) begin
            chk("done_time", time_ms, e.t);
            chk("done_valid", result_valid, e.v);
            chk("done_early", early_flag, e.e);
            chk("done_led_go", led_go, 0);
`ifdef REACTION_BEST_EN
            chk("done_best", best_ms, e.best);
`endif
            last = e;
            have_done = 1;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pb = 0; pg = 0; have_done = 0;
        end else begin
            if (busy && !pb) take(0);
            if (led_go && !pg) take(1);
            if (!busy && pb) take(2);
            else if (!busy && have_done) begin
                chk("hold_time", time_ms, last.t);
                chk("hold_flags", {result_valid, early_flag}, {last.v, last.e});
            end
            if (busy) begin
                chk("busy_flags_clear", {result_valid, early_flag}, 0);
                have_done = 0;
            end
            if (led_go) chk("go_implies_busy", busy, 1);
            if (time_ms > 9999) chk("time_bound", time_ms, 9999);
            pb = busy; pg = led_go;
        end
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 check_reset();
        rst_n = 1;
        round(1, 400, 0);
        round(1, 320, 0);
        round(1, 500, 0);
        round(0, int'($urandom_range(0, 999)), 1'($urandom_range(0, 1)));
        w = 0;
        while (m_lfsr[10:0] != 11'd0 && w < 20000) begin
            drive(0, 0, 0);
            w++;
        end
        chk("lfsr_low_zero_reached", int'(w < 20000), 1);
        round(1, 250, 0);
        round(0, 300, 0);
        round(1, 40, 1);
        round(2, 0, 0);
        repeat (2) round(1, int'($urandom_range(0, 600)), 1'($urandom_range(0, 1)));
        round(3, 77, 0);
        repeat (4) drive(0, 0, 0);
        round(1, int'($urandom_range(0, 100)), 0);
        repeat (3) drive(0, 0, 0);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
